// File: rtl/id_hazard_if.sv
// Decode-stage hazard bus: ID instruction fields in, front-end pipeline controls out.
interface id_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  memread_id;
  logic                  multicycle_id;
  logic                  branch_taken_ex;
  logic                  pcwrite;
  logic                  ifidwrite;
  logic                  ifid_flush;
  logic                  clearcontrol;
  logic                  exhold;
  logic                  busy;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id,
           memread_id, multicycle_id, branch_taken_ex,
    input  pcwrite, ifidwrite, ifid_flush, clearcontrol, exhold, busy, stall_cycles
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id,
           memread_id, multicycle_id, branch_taken_ex,
    output pcwrite, ifidwrite, ifid_flush, clearcontrol, exhold, busy, stall_cycles
  );
endinterface

// File: rtl/id_hazard_scheduler.sv
// Front-end hazard scheduler: load-use bubbles, multi-cycle EX hold, taken-branch flush.
// Controls are combinational in the ID cycle; the front end stalls whenever pcwrite=0.
module id_hazard_scheduler #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  id_hazard_if.slave hz
);
  typedef enum logic {RUN, MC_BUSY} state_t;

  localparam logic [3:0] MC_INIT = 4'(MC_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            mc_cnt_q, mc_cnt_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_memread_q, ex_memread_d;
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic pcwrite, ifidwrite, ifid_flush, clearcontrol, exhold, busy;
  logic load_use;

  // x0 is hardwired zero, so a load targeting it can never be a producer.
  assign load_use = ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                    ((hz.rs1_used && (hz.rs1_id == ex_rd_q)) ||
                     (hz.rs2_used && (hz.rs2_id == ex_rd_q)));

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    pcwrite      = 1'b1;
    ifidwrite    = 1'b1;
    ifid_flush   = 1'b0;
    clearcontrol = 1'b0;
    exhold       = 1'b0;
    busy         = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.branch_taken_ex) begin
          ifid_flush   = 1'b1;
          clearcontrol = 1'b1;
        end else if (load_use) begin
          pcwrite      = 1'b0;
          ifidwrite    = 1'b0;
          clearcontrol = 1'b1;
        end else if (hz.id_valid && hz.multicycle_id) begin
          state_d  = MC_BUSY;
          mc_cnt_d = MC_INIT;
        end
      end
      MC_BUSY: begin
        exhold    = 1'b1;
        pcwrite   = 1'b0;
        ifidwrite = 1'b0;
        busy      = 1'b1;
        mc_cnt_d  = mc_cnt_q - 4'd1;
        if (mc_cnt_q == 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rd_d      = ex_rd_q;
    ex_memread_d = ex_memread_q;
    if (!exhold) begin
      if (hz.id_valid && !clearcontrol) begin
        ex_valid_d   = 1'b1;
        ex_rd_d      = hz.rd_id;
        ex_memread_d = hz.memread_id;
      end else begin
        ex_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pcwrite && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      mc_cnt_q     <= '0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
      ex_memread_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      mc_cnt_q     <= mc_cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_memread_q <= ex_memread_d;
      stall_q      <= stall_d;
    end
  end

  assign hz.pcwrite      = pcwrite;
  assign hz.ifidwrite    = ifidwrite;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.clearcontrol = clearcontrol;
  assign hz.exhold       = exhold;
  assign hz.busy         = busy;
  assign hz.stall_cycles = stall_q;
endmodule

// File: doc/id_hazard_scheduler.md
# id_hazard_scheduler

Pipeline hazard scheduler that sequences the front end (PC, IF/ID, ID/EX) around the instruction-decode stage. It tracks the instruction occupying EX. It generates load-use bubbles, holds the pipeline while a multi-cycle EX operation completes, and flushes wrong-path instructions on a taken branch/jump. It replaces ad-hoc stall logic. It drives the pcwrite, ifidwrite and clearcontrol controls consumed by the fetch stage and the decode control unit.

## Interface
- REG_ADDR_W, 5, register-index width
- MC_LATENCY, 4, total EX cycles of a multi-cycle op; legal range 2..15
- CNT_W, 16, stall performance-counter width

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction (not a bubble)
- rs1_id, rs2_id  in  REG_ADDR_W  ID source indices
- rs1_used, rs2_used  in  1  ID instruction actually reads rs1/rs2
- rd_id  in  REG_ADDR_W  ID destination index
- memread_id  in  1  ID instruction is a load
- multicycle_id  in  1  ID instruction is a multi-cycle EX op
- branch_taken_ex  in  1  EX resolved a taken branch/jal/jalr this cycle
- pcwrite  out  1  PC may update
- ifidwrite  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID loads a bubble
- clearcontrol  out  1  ID/EX receives zeroed controls (bubble)
- exhold  out  1  ID/EX and EX unit hold; EX/MEM loads a bubble
- busy  out  1  FSM in MC_BUSY
- stall_cycles  out  CNT_W  saturating count of cycles with pcwrite=0

## Operation
- EX tracker (ex_valid, ex_rd, ex_memread) updates on every edge where exhold=0:
  - captures ID fields when id_valid=1 and clearcontrol=0;
  - otherwise ex_valid<=0.
- Load-use hazard: ex_valid & ex_memread & ex_rd!=0 & ((rs1_used & rs1_id==ex_rd) | (rs2_used & rs2_id==ex_rd)).
- FSM states: RUN, MC_BUSY; 4-bit down-counter mc_cnt.
- RUN, priority order:
  1. branch_taken_ex=1 → pcwrite=1, ifidwrite=1, ifid_flush=1, clearcontrol=1. Load-use and multi-cycle issue are ignored this cycle.
  2. Load-use → pcwrite=0, ifidwrite=0, clearcontrol=1 (one bubble).
  3. Otherwise → pcwrite=1, ifidwrite=1, clearcontrol=0. If id_valid & multicycle_id, the next state is MC_BUSY and mc_cnt<=MC_LATENCY-1.
- MC_BUSY:
  - exhold=1, pcwrite=0, ifidwrite=0, clearcontrol=0, ifid_flush=0, busy=1.
  - branch_taken_ex and load-use are ignored.
  - mc_cnt decrements each cycle. When mc_cnt==1, the next state is RUN.
- ifid_flush=0 and exhold=0 in every case not listed above.
- stall_cycles increments on each edge where pcwrite=0 and saturates at 2^CNT_W-1.
- A rd of x0 never creates a hazard.

## Timing
- All hazard outputs are combinational from the current state, the tracker and the ID inputs. They are valid in the same cycle as the ID instruction. No input-to-output register stage.
- Load-use costs exactly 1 bubble cycle. The dependent instruction is re-evaluated next cycle against a tracker that is then empty.
- A multi-cycle op spends MC_LATENCY cycles in EX, giving MC_LATENCY-1 front-end stall cycles. The instruction behind it issues on the first RUN cycle.
- Back-to-back multi-cycle ops: the second issues on the first RUN cycle and re-enters MC_BUSY. There is no idle cycle between them.
- A taken branch costs 2 flushed slots: IF/ID and ID/EX, both in the same cycle.
- A branch coinciding with a load-use or multi-cycle issue: the branch wins, the ID instruction is squashed, and the FSM stays in RUN.
- Reset (asynchronous, any state including mid-MC_BUSY): state=RUN, mc_cnt=0, ex_valid=0, ex_rd=0, ex_memread=0, stall_cycles=0.
  - Outputs during and after reset: pcwrite=1, ifidwrite=1, ifid_flush=0, clearcontrol=0, exhold=0, busy=0.
  - No pending stall survives reset.

## Test plan
- Reset: assert rst mid-MC_BUSY with mc_cnt=2 → outputs return to reset values immediately; the next cycle is RUN with pcwrite=1.
- Load-use:
  - Load rd=x5 in EX, ID reads rs2=x5 with rs2_used=1 → one cycle of pcwrite=0, ifidwrite=0, clearcontrol=1, then pcwrite=1; stall_cycles=1.
  - Same case with rs2_used=0, or rd=x0 → no stall.
- Multi-cycle, MC_LATENCY=4: issue multicycle_id → exactly 3 cycles with exhold=1 and busy=1. A following multi-cycle op issues immediately afterwards → 3 more busy cycles; stall_cycles=6.
- Branch priority: branch_taken_ex=1 while the ID load-use condition holds and multicycle_id=1 → ifid_flush=1, clearcontrol=1, pcwrite=1, and the FSM stays RUN.
- Branch during MC_BUSY: branch_taken_ex pulsed → ignored; exhold stays 1 until the count expires.
- Saturation: CNT_W=4, hold load-use for 20 cycles → stall_cycles stops at 15.
